alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL use one clock `clk`, and its reset `reset` SHALL be synchronous and active-high.
REQ-002 Parameter: CNT_W, default 16, width of the retired-instruction counter.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: cmd_valid  input  1  instruction offered.
REQ-006 Port: cmd_ready  output  1  instruction accepted when high with cmd_valid.
REQ-007 Port: cmd_instr  input  16  instruction word.
REQ-008 Port: rf_op  output  ALUOp  operation driven to the register-file/ALU.
REQ-009 Port: rf_addr_a, rf_addr_b, rf_addr_r  output  3 each  register-file operand, second-operand and result addresses.
REQ-010 Port: rf_data_in  output  8  write data.
REQ-011 Port: rf_data_out  input  8  register-file read data, valid one cycle after REG_READ is issued.
REQ-012 Port: rsp_valid  output  1  read result available.
REQ-013 Port: rsp_ready  input  1  consumer accepts the result.
REQ-014 Port: rsp_data  output  8  read result.
REQ-015 Port: rsp_addr  output  3  register that was read.
REQ-016 Port: retired  output  CNT_W  count of completed instructions.

Function
REQ-017 Instruction format: [15:14] opcode. LOAD=00 uses rd [13:11] and imm [7:0]. ADD=01 uses rr [13:11], ra [10:8] and rb [7:5]. READ=10 uses ra [10:8]. NOP=11.
REQ-018 FSM states SHALL be IDLE, ISSUE, ADD_SETTLE, READ_CAP and RESP.
REQ-019 cmd_ready SHALL be high only in IDLE; a handshake SHALL latch cmd_instr and move the FSM to ISSUE.
REQ-020 In ISSUE the block SHALL drive decoded fields for one cycle.
- LOAD: rf_op=REG_WRITE, rf_addr_a=rd, rf_data_in=imm.
- ADD: rf_op=ADD with ra/rb/rr.
- READ: rf_op=REG_READ, rf_addr_a=ra.
- NOP: rf_op=NOP.
REQ-021 LOAD and NOP SHALL go ISSUE->IDLE.
REQ-022 ADD SHALL go ISSUE->ADD_SETTLE->IDLE, holding its addresses with rf_op=NOP in ADD_SETTLE.
REQ-023 READ SHALL go ISSUE->READ_CAP, capture rf_data_out into rsp_data and ra into rsp_addr, then go to RESP.
REQ-024 In RESP, rsp_valid SHALL be high and rsp_data/rsp_addr SHALL be stable until rsp_ready is high; on that handshake the FSM SHALL go to IDLE.
REQ-025 A rsp_ready high in RESP in the first cycle SHALL complete the response in that cycle.
REQ-026 Outside ISSUE, rf_op SHALL be NOP.
REQ-027 Back-to-back latency: LOAD/NOP 2 cycles; ADD 3 cycles; READ 3 cycles to rsp_valid.
REQ-028 retired SHALL increment by 1 when each instruction finishes: the ISSUE->IDLE transition, the ADD_SETTLE exit, or the RESP handshake. It SHALL wrap from all-ones to 0.
REQ-029 cmd_valid while the block is busy SHALL be ignored, with no latching and no side effect.

Reset
REQ-030 When reset is high at a rising edge, the block SHALL enter IDLE and drive the following next cycle: rf_op=NOP, all rf_addr_*=0, rf_data_in=0, rsp_valid=0, rsp_data=0, rsp_addr=0, retired=0, cmd_ready=1.
REQ-031 Reset mid-operation, in any state, SHALL abort the instruction with no retire and any pending response dropped.
REQ-032 Reset SHALL take priority over a simultaneous cmd or rsp handshake.

Structure
REQ-033 constants_pkg SHALL gain a NOP member in ALUOp, plus the SeqOpcode enum (LOAD, ADD, READ, NOP) and the field bit-position constants.
REQ-034 The FSM state enum SHALL be local to the module.
REQ-035 Decoding SHALL live in one combinational sub-module, alu_instr_decode, that maps instruction to op, addresses and imm.

Verification
REQ-036 LOAD r0=0x42, LOAD r1=0x24, ADD r2=r0+r1, READ r2 against the real alu_registers model -> rsp_data=0x66, rsp_addr=2, retired=4.
REQ-037 Fibonacci stream (r1=1, r2=1, ADD r3..r7), then READ r7 -> rsp_data=0x0D, with rf_op=ADD asserted for exactly one cycle per ADD.
REQ-038 READ r5 with rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stay stable and cmd_ready stays 0; releasing rsp_ready returns the FSM to IDLE next cycle.
REQ-039 cmd_valid held high continuously during an ADD -> only one instruction is latched; the next is accepted exactly 3 cycles after the first.
REQ-040 Reset asserted in READ_CAP and in RESP -> next cycle rsp_valid=0, retired=0, rf_op=NOP, cmd_ready=1.
REQ-041 With CNT_W=4, 16 NOPs -> retired wraps to 0 and rf_op stays NOP throughout.

Source files
------------

// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared ALU op codes, sequencer opcodes and instruction field positions
package constants_pkg;

    typedef enum logic [1:0] {
        NOP       = 2'b00,
        ADD       = 2'b01,
        REG_WRITE = 2'b10,
        REG_READ  = 2'b11
    } ALUOp;

    // Prefixed so the literals do not collide with the ALUOp members.
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_READ = 2'b10,
        OP_NOP  = 2'b11
    } SeqOpcode;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 14;
    localparam int RD_HI  = 13;
    localparam int RD_LO  = 11;
    localparam int RR_HI  = 13;
    localparam int RR_LO  = 11;
    localparam int RA_HI  = 10;
    localparam int RA_LO  = 8;
    localparam int RB_HI  = 7;
    localparam int RB_LO  = 5;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/alu_instr_decode.sv
// rtl/alu_instr_decode.sv - combinational decode of a sequencer instruction word
module alu_instr_decode
    import constants_pkg::*;
(
    input  logic [15:0] instr_i,
    output SeqOpcode    seq_op_o,
    output ALUOp        alu_op_o,
    output logic [2:0]  addr_a_o,
    output logic [2:0]  addr_b_o,
    output logic [2:0]  addr_r_o,
    output logic [7:0]  imm_o
);

    always_comb begin
        seq_op_o = SeqOpcode'(instr_i[OPC_HI:OPC_LO]);
        alu_op_o = NOP;
        addr_a_o = 3'd0;
        addr_b_o = 3'd0;
        addr_r_o = 3'd0;
        imm_o    = 8'd0;
        case (seq_op_o)
            OP_LOAD: begin
                alu_op_o = REG_WRITE;
                addr_a_o = instr_i[RD_HI:RD_LO];
                imm_o    = instr_i[IMM_HI:IMM_LO];
            end
            OP_ADD: begin
                alu_op_o = ADD;
                addr_r_o = instr_i[RR_HI:RR_LO];
                addr_a_o = instr_i[RA_HI:RA_LO];
                addr_b_o = instr_i[RB_HI:RB_LO];
            end
            OP_READ: begin
                alu_op_o = REG_READ;
                addr_a_o = instr_i[RA_HI:RA_LO];
            end
            default: alu_op_o = NOP;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - accepts one instruction at a time and sequences it onto the register-file/ALU port
module alu_op_sequencer
    import constants_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_instr,
    output ALUOp             rf_op,
    output logic [2:0]       rf_addr_a,
    output logic [2:0]       rf_addr_b,
    output logic [2:0]       rf_addr_r,
    output logic [7:0]       rf_data_in,
    input  logic [7:0]       rf_data_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic [2:0]       rsp_addr,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ADD_SETTLE,
        READ_CAP,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        instr_q;
    logic [7:0]         rsp_data_q;
    logic [2:0]         rsp_addr_q;
    logic [CNT_W-1:0]   retired_q;
    logic               retire;
    logic               capture;

    SeqOpcode           dec_seq;
    ALUOp               dec_op;
    logic [2:0]         dec_a, dec_b, dec_r;
    logic [7:0]         dec_imm;

    alu_instr_decode u_decode (
        .instr_i  (instr_q),
        .seq_op_o (dec_seq),
        .alu_op_o (dec_op),
        .addr_a_o (dec_a),
        .addr_b_o (dec_b),
        .addr_r_o (dec_r),
        .imm_o    (dec_imm)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            instr_q    <= 16'd0;
            rsp_data_q <= 8'd0;
            rsp_addr_q <= 3'd0;
            retired_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid) begin
                instr_q <= cmd_instr;
            end
            if (capture) begin
                rsp_data_q <= rf_data_out;
                rsp_addr_q <= dec_a;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (cmd_valid) state_d = ISSUE;
            ISSUE: begin
                case (dec_seq)
                    OP_ADD:  state_d = ADD_SETTLE;
                    OP_READ: state_d = READ_CAP;
                    default: state_d = IDLE;
                endcase
            end
            ADD_SETTLE: state_d = IDLE;
            READ_CAP:   state_d = RESP;
            RESP:       if (rsp_ready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Addresses stay on the bus through ADD_SETTLE so the ALU result path sees stable operands.
    always_comb begin
        cmd_ready  = 1'b0;
        rf_op      = NOP;
        rf_addr_a  = 3'd0;
        rf_addr_b  = 3'd0;
        rf_addr_r  = 3'd0;
        rf_data_in = 8'd0;
        rsp_valid  = 1'b0;
        retire     = 1'b0;
        capture    = 1'b0;
        case (state_q)
            IDLE: cmd_ready = 1'b1;
            ISSUE: begin
                rf_op      = dec_op;
                rf_addr_a  = dec_a;
                rf_addr_b  = dec_b;
                rf_addr_r  = dec_r;
                rf_data_in = dec_imm;
                retire     = (dec_seq == OP_LOAD) || (dec_seq == OP_NOP);
            end
            ADD_SETTLE: begin
                rf_addr_a = dec_a;
                rf_addr_b = dec_b;
                rf_addr_r = dec_r;
                retire    = 1'b1;
            end
            READ_CAP: capture = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                retire    = rsp_ready;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    assign rsp_data = rsp_data_q;
    assign rsp_addr = rsp_addr_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer with a register-file model
module tb_alu_op_sequencer;
    import constants_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_instr;
    ALUOp        rf_op;
    logic [2:0]  rf_addr_a, rf_addr_b, rf_addr_r;
    logic [7:0]  rf_data_in;
    logic [7:0]  rf_data_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [2:0]  rsp_addr;
    logic [3:0]  retired;

    int n_checks = 0;
    int n_fail   = 0;
    int add_total = 0;
    int snap;
    logic [7:0] regs [8];

    always #5 clk = ~clk;

    alu_op_sequencer #(.CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_instr   (cmd_instr),
        .rf_op       (rf_op),
        .rf_addr_a   (rf_addr_a),
        .rf_addr_b   (rf_addr_b),
        .rf_addr_r   (rf_addr_r),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_addr    (rsp_addr),
        .retired     (retired)
    );

    // Register file: writes and adds commit at the edge, reads return one cycle later.
    always @(posedge clk) begin
        if (rf_op == REG_WRITE) regs[rf_addr_a] <= rf_data_in;
        else if (rf_op == ADD)  regs[rf_addr_r] <= regs[rf_addr_a] + regs[rf_addr_b];
        if (rf_op == REG_READ)  rf_data_out <= regs[rf_addr_a];
    end

    always @(negedge clk) if (rf_op == ADD) add_total++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the ISSUE cycle.
    task automatic send(input logic [15:0] ins);
        int t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("send_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_instr = ins;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rf_op"}, rf_op, NOP);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_retired"}, retired, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_addr"}, rsp_addr, 0);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_instr = 16'h0000;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        check("rst_addrs", {rf_addr_a, rf_addr_b, rf_addr_r}, 0);
        check("rst_data_in", rf_data_in, 0);
        reset = 1'b0;

        // r0=0x42, r1=0x24, r2=r0+r1, read r2
        send(16'h0042);
        check("load_op", rf_op, REG_WRITE);
        check("load_addr", rf_addr_a, 0);
        check("load_imm", rf_data_in, 8'h42);
        @(negedge clk);
        check("load_lat_ready", cmd_ready, 1);
        check("load_retired", retired, 1);
        send(16'h0824);
        send(16'h5020);
        check("add_op", rf_op, ADD);
        check("add_addrs", {rf_addr_r, rf_addr_a, rf_addr_b}, {3'd2, 3'd0, 3'd1});
        @(negedge clk);
        check("settle_op", rf_op, NOP);
        check("settle_addr_r", rf_addr_r, 2);
        check("settle_ready", cmd_ready, 0);
        @(negedge clk);
        check("add_lat_ready", cmd_ready, 1);
        send(16'h8200);
        check("read_op", rf_op, REG_READ);
        @(negedge clk);
        check("readcap_valid", rsp_valid, 0);
        check("readcap_op", rf_op, NOP);
        @(negedge clk);
        check("read_valid", rsp_valid, 1);
        check("read_data", rsp_data, 8'h66);
        check("read_addr", rsp_addr, 2);
        check("read_ret_pre", retired, 3);
        @(negedge clk);
        check("read_done_ready", cmd_ready, 1);
        check("read_retired", retired, 4);

        // Fibonacci r1..r7, read r7
        snap = add_total;
        send(16'h0801);
        send(16'h1001);
        send(16'h5940);
        send(16'h6260);
        send(16'h6B80);
        send(16'h74A0);
        send(16'h7DC0);
        send(16'h8700);
        wait_rsp();
        check("fib_data", rsp_data, 8'h0D);
        check("fib_addr", rsp_addr, 7);
        check("fib_add_cycles", add_total - snap, 5);
        @(negedge clk);
        check("fib_retired", retired, 12);

        // Response held off by rsp_ready low
        rsp_ready = 1'b0;
        send(16'h8500);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, 8'h05);
            check("hold_ready", cmd_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_ready", cmd_ready, 1);
        check("release_valid", rsp_valid, 0);
        check("release_retired", retired, 13);

        // cmd_valid held high through an ADD
        cmd_valid = 1'b1;
        cmd_instr = 16'h5940;
        @(negedge clk);
        check("busy_issue_op", rf_op, ADD);
        cmd_instr = 16'hC000;
        @(negedge clk);
        check("busy_settle_ready", cmd_ready, 0);
        check("busy_settle_op", rf_op, NOP);
        @(negedge clk);
        check("busy_accept_ready", cmd_ready, 1);
        check("busy_retired", retired, 14);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_nop_ready", cmd_ready, 0);
        check("busy_nop_op", rf_op, NOP);
        @(negedge clk);
        check("busy_nop_retired", retired, 15);
        check("busy_r3", regs[3], 8'h02);

        // Reset in READ_CAP
        send(16'h8300);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("rst_cap");
        reset = 1'b0;

        // Reset in RESP with a pending response
        rsp_ready = 1'b0;
        send(16'h8300);
        wait_rsp();
        check("pre_rst_valid", rsp_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("rst_resp");
        reset = 1'b0;
        rsp_ready = 1'b1;

        // 16 NOPs wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            send(16'hC000);
            check("nop_op", rf_op, NOP);
            check("nop_ret", retired, i);
        end
        @(negedge clk);
        check("nop_wrap", retired, 0);
        check("nop_end_op", rf_op, NOP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
